// File: rtl/proc_control_unit.sv
// proc_control_unit: sequencing FSM for the 16-bit multi-cycle processor.
// Fetches each instruction over the shared bus, then drives the register
// enables and bus selects that execute it. Holds no data, only state.
// Optional feature macro: CU_SINGLE_STEP_EN -- when defined, the FSM parks in
// HALT after every instruction and only resumes on a rising edge of run.
module proc_control_unit #(
   parameter int IR_W    = 10,
   parameter int NREG    = 8,
   parameter int MEM_LAT = 1
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            run,
   input  logic [IR_W-1:0] ir,
   input  logic            g_nz,
   output logic [NREG-1:0] rin,
   output logic [NREG-1:0] rout,
   output logic            ain,
   output logic            gin,
   output logic            gout,
   output logic            addsub,
   output logic            din_out,
   output logic            ir_in,
   output logic            addr_in,
   output logic            dout_in,
   output logic            w_d,
   output logic            incr_pc,
   output logic            sp_out,
   output logic            sp_inc,
   output logic            sp_dec,
   output logic            done,
   output logic [3:0]      state_dbg
);

   typedef enum logic [3:0] {
      S_F0   = 4'd0,
      S_FW   = 4'd1,
      S_F2   = 4'd2,
      S_E1   = 4'd3,
      S_E2   = 4'd4,
      S_E3   = 4'd5,
      S_E4   = 4'd6,
      S_EW   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   localparam logic [3:0] OP_MV   = 4'd0;
   localparam logic [3:0] OP_MVI  = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_LD   = 4'd4;
   localparam logic [3:0] OP_ST   = 4'd5;
   localparam logic [3:0] OP_MVNZ = 4'd6;
   localparam logic [3:0] OP_PUSH = 4'd7;
   localparam logic [3:0] OP_POP  = 4'd8;

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
   localparam logic [NREG-1:0] PC_OH = {1'b1, {(NREG-1){1'b0}}};

`ifdef CU_SINGLE_STEP_EN
   localparam state_t S_AFTER = S_HALT;
`else
   localparam state_t S_AFTER = S_F0;
`endif

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [3:0]      op;
   logic [2:0]      rx;
   logic [2:0]      ry;
   logic [NREG-1:0] ohx;
   logic [NREG-1:0] ohy;
`ifdef CU_SINGLE_STEP_EN
   logic            run_q;
`endif

   // One-hot register select from a 3-bit register field
   function automatic logic [NREG-1:0] reg_oh(input logic [2:0] idx);
      logic [NREG-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign op  = ir[IR_W-1 -: 4];
   assign rx  = ir[5:3];
   assign ry  = ir[2:0];
   assign ohx = reg_oh(rx);
   assign ohy = reg_oh(ry);

   // State sequencing and memory-wait counter
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= S_F0;
         cnt   <= '0;
`ifdef CU_SINGLE_STEP_EN
         run_q <= 1'b0;
`endif
      end else begin
`ifdef CU_SINGLE_STEP_EN
         run_q <= run;
`endif
         case (state)
            S_F0: begin
               if (run) begin
                  state <= S_FW;
                  cnt   <= '0;
               end else begin
                  state <= S_F0;
               end
            end
            S_FW: begin
               if (cnt == CNT_LAST) begin
                  state <= S_F2;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_F2: state <= S_E1;
            S_E1: begin
               case (op)
                  OP_MVI, OP_LD, OP_POP: begin
                     state <= S_EW;
                     cnt   <= '0;
                  end
                  OP_ADD, OP_SUB, OP_ST, OP_PUSH: state <= S_E2;
                  default: state <= S_AFTER;
               endcase
            end
            S_E2: state <= S_E3;
            S_E3: begin
               if (op == OP_PUSH) begin
                  state <= S_E4;
               end else begin
                  state <= S_AFTER;
               end
            end
            S_E4: state <= S_AFTER;
            S_EW: begin
               if (cnt == CNT_LAST) begin
                  state <= S_E3;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`ifdef CU_SINGLE_STEP_EN
            S_HALT: begin
               if (run && !run_q) begin
                  state <= S_F0;
               end else begin
                  state <= S_HALT;
               end
            end
`endif
            default: state <= S_F0;
         endcase
      end
   end

   // Control decode: outputs from state and instruction fields, gated off in reset
   always_comb begin
      rin       = '0;
      rout      = '0;
      ain       = 1'b0;
      gin       = 1'b0;
      gout      = 1'b0;
      addsub    = 1'b0;
      din_out   = 1'b0;
      ir_in     = 1'b0;
      addr_in   = 1'b0;
      dout_in   = 1'b0;
      w_d       = 1'b0;
      incr_pc   = 1'b0;
      sp_out    = 1'b0;
      sp_inc    = 1'b0;
      sp_dec    = 1'b0;
      done      = 1'b0;
      state_dbg = 4'd0;
      if (!resetn) begin
         state_dbg = 4'd0;
      end else begin
         state_dbg = state;
         case (state)
            S_F0: begin
               if (run) begin
                  rout    = PC_OH;
                  addr_in = 1'b1;
               end else begin
                  addr_in = 1'b0;
               end
            end
            S_FW: incr_pc = (cnt == '0);
            S_F2: begin
               din_out = 1'b1;
               ir_in   = 1'b1;
            end
            S_E1: begin
               case (op)
                  OP_MV: begin
                     rout = ohy;
                     rin  = ohx;
                     done = 1'b1;
                  end
                  OP_MVI: begin
                     rout    = PC_OH;
                     addr_in = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     rout = ohx;
                     ain  = 1'b1;
                  end
                  OP_LD, OP_ST: begin
                     rout    = ohy;
                     addr_in = 1'b1;
                  end
                  OP_MVNZ: begin
                     if (g_nz) begin
                        rout = ohy;
                        rin  = ohx;
                     end else begin
                        rin = '0;
                     end
                     done = 1'b1;
                  end
                  OP_PUSH: sp_dec = 1'b1;
                  OP_POP: begin
                     sp_out  = 1'b1;
                     addr_in = 1'b1;
                  end
                  default: done = 1'b1;
               endcase
            end
            S_E2: begin
               case (op)
                  OP_ADD, OP_SUB: begin
                     rout   = ohy;
                     gin    = 1'b1;
                     addsub = op[0];
                  end
                  OP_ST: begin
                     rout    = ohx;
                     dout_in = 1'b1;
                  end
                  OP_PUSH: begin
                     sp_out  = 1'b1;
                     addr_in = 1'b1;
                  end
                  default: rout = '0;
               endcase
            end
            S_E3: begin
               case (op)
                  OP_ADD, OP_SUB: begin
                     gout = 1'b1;
                     rin  = ohx;
                     done = 1'b1;
                  end
                  OP_MVI, OP_LD: begin
                     din_out = 1'b1;
                     rin     = ohx;
                     done    = 1'b1;
                  end
                  OP_ST: begin
                     w_d  = 1'b1;
                     done = 1'b1;
                  end
                  OP_PUSH: begin
                     rout    = ohx;
                     dout_in = 1'b1;
                  end
                  OP_POP: begin
                     din_out = 1'b1;
                     rin     = ohx;
                     sp_inc  = 1'b1;
                     done    = 1'b1;
                  end
                  default: rout = '0;
               endcase
            end
            S_E4: begin
               if (op == OP_PUSH) begin
                  w_d  = 1'b1;
                  done = 1'b1;
               end else begin
                  w_d = 1'b0;
               end
            end
            S_EW: incr_pc = (cnt == '0) && (op == OP_MVI);
            default: rout = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: directed and random instructions compared
// cycle by cycle against a micro-op sequence model of the instruction set.
// Honours CU_SINGLE_STEP_EN when the design is built with it.
module tb_proc_control_unit;

   localparam int MEM_LAT = 1;

   // Flag positions inside the packed output vector {rin, rout, flags}
   localparam logic [13:0] AIN   = 14'h2000;
   localparam logic [13:0] GIN   = 14'h1000;
   localparam logic [13:0] GOUT  = 14'h0800;
   localparam logic [13:0] ADDSB = 14'h0400;
   localparam logic [13:0] DIN   = 14'h0200;
   localparam logic [13:0] IRIN  = 14'h0100;
   localparam logic [13:0] ADDR  = 14'h0080;
   localparam logic [13:0] DOUT  = 14'h0040;
   localparam logic [13:0] WD    = 14'h0020;
   localparam logic [13:0] INCPC = 14'h0010;
   localparam logic [13:0] SPOUT = 14'h0008;
   localparam logic [13:0] SPINC = 14'h0004;
   localparam logic [13:0] SPDEC = 14'h0002;
   localparam logic [13:0] DONE  = 14'h0001;
   localparam logic [13:0] NOFL  = 14'h0000;

   typedef logic [29:0] vq_t[$];

   logic       clock = 1'b0;
   logic       resetn;
   logic       run;
   logic [9:0] ir;
   logic       g_nz;
   logic [7:0] rin, rout;
   logic       ain, gin, gout, addsub, din_out, ir_in, addr_in, dout_in;
   logic       w_d, incr_pc, sp_out, sp_inc, sp_dec, done;
   logic [3:0] state_dbg;
   logic [29:0] obs;

   int total = 0;
   int bad   = 0;

   proc_control_unit #(.IR_W(10), .NREG(8), .MEM_LAT(MEM_LAT)) dut (
      .clock(clock), .resetn(resetn), .run(run), .ir(ir), .g_nz(g_nz),
      .rin(rin), .rout(rout), .ain(ain), .gin(gin), .gout(gout),
      .addsub(addsub), .din_out(din_out), .ir_in(ir_in), .addr_in(addr_in),
      .dout_in(dout_in), .w_d(w_d), .incr_pc(incr_pc), .sp_out(sp_out),
      .sp_inc(sp_inc), .sp_dec(sp_dec), .done(done), .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   assign obs = {rin, rout, ain, gin, gout, addsub, din_out, ir_in, addr_in,
                 dout_in, w_d, incr_pc, sp_out, sp_inc, sp_dec, done};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [29:0] uop(input logic [7:0] ri, input logic [7:0] ro, input logic [13:0] fl);
      return {ri, ro, fl};
   endfunction

   // Expected per-cycle outputs of one whole instruction: fetch then execute
   function automatic vq_t model(input logic [3:0] op, input logic [2:0] rx,
                                 input logic [2:0] ry, input logic gnz);
      vq_t q;
      logic [7:0] ohx;
      logic [7:0] ohy;
      ohx = 8'd1 << rx;
      ohy = 8'd1 << ry;
      q = {};
      q.push_back(uop(8'h00, 8'h80, ADDR));
      for (int i = 0; i < MEM_LAT; i++) q.push_back(uop(8'h00, 8'h00, (i == 0) ? INCPC : NOFL));
      q.push_back(uop(8'h00, 8'h00, DIN | IRIN));
      case (op)
         4'd0: q.push_back(uop(ohx, ohy, DONE));
         4'd1: begin
            q.push_back(uop(8'h00, 8'h80, ADDR));
            for (int i = 0; i < MEM_LAT; i++) q.push_back(uop(8'h00, 8'h00, (i == 0) ? INCPC : NOFL));
            q.push_back(uop(ohx, 8'h00, DIN | DONE));
         end
         4'd2, 4'd3: begin
            q.push_back(uop(8'h00, ohx, AIN));
            q.push_back(uop(8'h00, ohy, GIN | (op[0] ? ADDSB : NOFL)));
            q.push_back(uop(ohx, 8'h00, GOUT | DONE));
         end
         4'd4: begin
            q.push_back(uop(8'h00, ohy, ADDR));
            for (int i = 0; i < MEM_LAT; i++) q.push_back(uop(8'h00, 8'h00, NOFL));
            q.push_back(uop(ohx, 8'h00, DIN | DONE));
         end
         4'd5: begin
            q.push_back(uop(8'h00, ohy, ADDR));
            q.push_back(uop(8'h00, ohx, DOUT));
            q.push_back(uop(8'h00, 8'h00, WD | DONE));
         end
         4'd6: q.push_back(gnz ? uop(ohx, ohy, DONE) : uop(8'h00, 8'h00, DONE));
         4'd7: begin
            q.push_back(uop(8'h00, 8'h00, SPDEC));
            q.push_back(uop(8'h00, 8'h00, SPOUT | ADDR));
            q.push_back(uop(8'h00, ohx, DOUT));
            q.push_back(uop(8'h00, 8'h00, WD | DONE));
         end
         4'd8: begin
            q.push_back(uop(8'h00, 8'h00, SPOUT | ADDR));
            for (int i = 0; i < MEM_LAT; i++) q.push_back(uop(8'h00, 8'h00, NOFL));
            q.push_back(uop(ohx, 8'h00, DIN | SPINC | DONE));
         end
         default: q.push_back(uop(8'h00, 8'h00, DONE));
      endcase
      return q;
   endfunction

   task automatic cycle_check(input string tag, input logic [29:0] want);
      int n;
      @(negedge clock);
      check_eq(tag, {2'b00, obs}, {2'b00, want});
      n = $countones(rout) + int'(gout) + int'(din_out) + int'(sp_out);
      check_eq({tag, "_bus"}, {31'd0, (n <= 1)}, 32'd1);
      @(posedge clock);
      #1;
   endtask

   // Inter-instruction gap: idle cycles, or HALT handling in single-step builds
   task automatic between();
`ifdef CU_SINGLE_STEP_EN
      run = 1'b1;
      repeat (3) cycle_check("halt_hold", 30'd0);
      run = 1'b0;
      cycle_check("halt_low", 30'd0);
      run = 1'b1;
      cycle_check("halt_rise", 30'd0);
`else
      int k;
      k = $urandom_range(2, 0);
      run = 1'b0;
      for (int i = 0; i < k; i++) cycle_check("idle", 30'd0);
      run = 1'b1;
`endif
   endtask

   task automatic run_instr(input logic [3:0] op, input logic [2:0] rx,
                            input logic [2:0] ry, input logic gnz);
      vq_t q;
      q = model(op, rx, ry, gnz);
      ir   = {op, rx, ry};
      g_nz = gnz;
      run  = 1'b1;
      foreach (q[i]) cycle_check($sformatf("op%0d_rx%0d_ry%0d_c%0d", op, rx, ry, i), q[i]);
      between();
   endtask

   initial begin
      vq_t q;
      resetn = 1'b0;
      run    = 1'b1;
      ir     = 10'd0;
      g_nz   = 1'b0;
      repeat (2) begin
         @(negedge clock);
         check_eq("reset_out", {2'b00, obs}, 32'd0);
         check_eq("reset_dbg", {28'd0, state_dbg}, 32'd0);
      end
      @(posedge clock);
      #1;
      resetn = 1'b1;

      // Directed cases
      run_instr(4'd1, 3'd0, 3'd0, 1'b0);   // mvi R0
      run_instr(4'd2, 3'd1, 3'd0, 1'b0);   // add R1,R0
      run_instr(4'd3, 3'd1, 3'd0, 1'b0);   // sub R1,R0
      run_instr(4'd6, 3'd7, 3'd2, 1'b0);   // mvnz R7,R2 not taken
      run_instr(4'd6, 3'd7, 3'd2, 1'b1);   // mvnz R7,R2 taken
      run_instr(4'd7, 3'd3, 3'd0, 1'b0);   // push R3
      run_instr(4'd8, 3'd4, 3'd0, 1'b0);   // pop R4
      run_instr(4'd0, 3'd5, 3'd6, 1'b0);   // mv R5,R6
      run_instr(4'd4, 3'd2, 3'd3, 1'b0);   // ld R2,[R3]
      run_instr(4'd5, 3'd7, 3'd1, 1'b0);   // st R7,[R1]
      run_instr(4'd15, 3'd1, 3'd1, 1'b1);  // nop encoding

      // st abandoned by reset in E2: no write may follow
      q = model(4'd5, 3'd2, 3'd1, 1'b0);
      ir  = {4'd5, 3'd2, 3'd1};
      run = 1'b1;
      for (int i = 0; i < 3 + MEM_LAT; i++) cycle_check($sformatf("st_pre_c%0d", i), q[i]);
      resetn = 1'b0;
      cycle_check("st_rst_e2", 30'd0);
      resetn = 1'b1;
      run    = 1'b0;
      repeat (3) cycle_check("st_post_rst", 30'd0);
      run_instr(4'd0, 3'd1, 3'd2, 1'b0);   // resumes from F0

      // Random instruction stream
      for (int n = 0; n < 200; n++) begin
         run_instr(4'($urandom_range(15, 0)), 3'($urandom_range(7, 0)),
                   3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
